// File: rtl/register_dump.sv
// Register-file sweep engine: walks debug read addresses 0..LAST_ADDR and
// presents each captured word as a valid/ready beat, pulsing done at the end.
module register_dump #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int LAST_ADDR = 31
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   dbg_addr_q, dbg_addr_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                at_last;

  assign at_last = (dbg_addr_q == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      dbg_addr_q  <= '0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dbg_addr_q  <= dbg_addr_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Abort outranks the downstream handshake in every active state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_ISSUE;
      S_ISSUE:   state_d = abort ? S_IDLE : S_WAIT;
      S_WAIT:    state_d = abort ? S_IDLE : S_PRESENT;
      S_PRESENT: begin
        if (abort)          state_d = S_IDLE;
        else if (out_ready) state_d = at_last ? S_DONE : S_ISSUE;
      end
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Read data is only trusted one cycle after the address settles, so it is
  // captured solely on the WAIT->PRESENT transition.
  always_comb begin
    dbg_addr_d  = dbg_addr_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start) dbg_addr_d = '0;
      end
      S_WAIT: begin
        if (!abort) begin
          out_data_d  = dbg_data;
          out_addr_d  = dbg_addr_q;
          out_valid_d = 1'b1;
        end
      end
      S_PRESENT: begin
        if (abort) begin
          out_valid_d = 1'b0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          if (!at_last) dbg_addr_d = dbg_addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign dbg_addr  = dbg_addr_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule
